carousel_collector: RTL and testbench

Receive-side counterpart of the carousel buffer. Accepts one word per lane from NUM_LANES independent valid/ready lanes, waits until every lane has delivered, then presents all lanes as one joined output word with a single valid/ready handshake. The lane order is rotated back by a per-transaction rotation count that tracks the transmit carousel's shift. It sits between per-lane producers and a single wide consumer.

---
 rtl/carousel_pkg.sv | 13 +
 rtl/carousel_collector_lane_rotate.sv | 22 ++
 rtl/carousel_collector.sv | 92 +++++++++
 tb/tb_carousel_collector.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/carousel_pkg.sv
// Shared types and helpers for the carousel receive path.
package carousel_pkg;

  typedef enum logic [0:0] {COLLECT, EMIT} carousel_rx_state_t;

  // Width of the rotation count for n lanes; never narrower than one bit.
  function automatic int unsigned rot_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w > 1) ? w : 1;
  endfunction

endpackage

// File: rtl/carousel_collector_lane_rotate.sv
// Combinational lane rotator: output lane i takes input lane (i + rot) mod NUM_LANES.
module lane_rotate
  import carousel_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 3,
  localparam int ROT_W     = rot_width(NUM_LANES)
) (
  input  logic [NUM_LANES*DATA_WIDTH-1:0] i_lanes,
  input  logic [ROT_W-1:0]                i_rot,
  output logic [NUM_LANES*DATA_WIDTH-1:0] o_lanes
);

  always_comb begin
    o_lanes = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      o_lanes[i*DATA_WIDTH +: DATA_WIDTH] =
        i_lanes[((i + int'(i_rot)) % NUM_LANES)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/carousel_collector.sv
// Joins NUM_LANES independent lane handshakes into one wide output word, undoing the
// transmit carousel's rotation. Rotation is enabled by CAROUSEL_COLLECTOR_ROTATE_EN.
module carousel_collector
  import carousel_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 3,
  localparam int ROT_W     = rot_width(NUM_LANES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_LANES-1:0]            data_in_valid,
  output logic [NUM_LANES-1:0]            data_in_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] data_out,
  output logic                            data_out_valid,
  input  logic                            data_out_ready,
  output logic [ROT_W-1:0]                rot_out
);

  carousel_rx_state_t              r_state;
  logic [NUM_LANES-1:0]            r_captured;
  logic [NUM_LANES*DATA_WIDTH-1:0] r_lane_reg;
  logic [NUM_LANES-1:0]            w_accept;
  logic                            w_all_in;
  logic                            w_out_fire;
  logic [ROT_W-1:0]                w_rot;

  // Readiness is a pure function of registered state so producers never see a loop.
  assign data_in_ready  = (r_state == COLLECT) ? ~r_captured : '0;
  assign w_accept       = data_in_valid & data_in_ready;
  assign w_all_in       = &(r_captured | w_accept);
  assign data_out_valid = (r_state == EMIT);
  assign w_out_fire     = data_out_valid & data_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= COLLECT;
      r_captured <= '0;
      r_lane_reg <= '0;
    end else begin
      unique case (r_state)
        COLLECT: begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (w_accept[i]) begin
              r_lane_reg[i*DATA_WIDTH +: DATA_WIDTH] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          r_captured <= r_captured | w_accept;
          if (w_all_in) begin
            r_state <= EMIT;
          end
        end
        EMIT: begin
          if (w_out_fire) begin
            r_captured <= '0;
            r_state    <= COLLECT;
          end
        end
      endcase
    end
  end

`ifdef CAROUSEL_COLLECTOR_ROTATE_EN
  logic [ROT_W-1:0] r_rot;

  // Advance once per emitted word, wrapping at NUM_LANES-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rot <= '0;
    end else if (w_out_fire) begin
      r_rot <= (r_rot == ROT_W'(NUM_LANES - 1)) ? '0 : r_rot + ROT_W'(1);
    end
  end

  assign w_rot = r_rot;
`else
  assign w_rot = '0;
`endif

  assign rot_out = w_rot;

  lane_rotate #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_LANES  (NUM_LANES)
  ) u_lane_rotate (
    .i_lanes (r_lane_reg),
    .i_rot   (w_rot),
    .o_lanes (data_out)
  );

endmodule

// File: tb/tb_carousel_collector.sv
// Self-checking bench for carousel_collector (3 lanes x 8 bits) with a transaction-level model.
module tb_carousel_collector;

  localparam int DW = 8;
  localparam int NL = 3;

  logic          clk;
  logic          rst;
  logic [23:0]   data_in;
  logic [2:0]    data_in_valid;
  logic [2:0]    data_in_ready;
  logic [23:0]   data_out;
  logic          data_out_valid;
  logic          data_out_ready;
  logic [1:0]    rot_out;

  int n_checks;
  int n_fail;
  int m_txn;   // words accepted since the last reset

  carousel_collector #(
    .DATA_WIDTH (DW),
    .NUM_LANES  (NL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .rot_out        (rot_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  function automatic int exp_rot();
`ifdef CAROUSEL_COLLECTOR_ROTATE_EN
    return m_txn % NL;
`else
    return 0;
`endif
  endfunction

  // Output lane i carries the input lane that sits r places further along.
  function automatic logic [23:0] exp_word(input logic [23:0] v, input int r);
    logic [23:0] o;
    o = '0;
    for (int i = 0; i < NL; i++) o[i*DW +: DW] = v[((i + r) % NL)*DW +: DW];
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: lane i arrives at cycle t_i, output held off for 'hold' cycles.
  task automatic run_txn(input logic [23:0] vals, input int t0, input int t1, input int t2,
                         input int hold, input string name);
    int          t[3];
    int          last;
    logic [2:0]  got;
    logic [23:0] exp;
    logic [1:0]  exp_r;
    t[0] = t0; t[1] = t1; t[2] = t2;
    last = t0;
    if (t1 > last) last = t1;
    if (t2 > last) last = t2;
    got   = '0;
    exp   = exp_word(vals, exp_rot());
    exp_r = 2'(exp_rot());
    for (int c = 0; c <= last; c++) begin
      for (int i = 0; i < NL; i++) begin
        if (t[i] == c) begin
          data_in_valid[i]     = 1'b1;
          data_in[i*DW +: DW] = vals[i*DW +: DW];
        end else begin
          // Already-captured lanes get junk that must be ignored.
          data_in_valid[i]     = got[i] ? 1'($urandom_range(0, 1)) : 1'b0;
          data_in[i*DW +: DW] = 8'($urandom);
        end
      end
      data_out_ready = 1'($urandom_range(0, 1));
      n_checks++;
      if (data_in_ready !== ~got) begin
        n_fail++;
        $display("FAIL %s cyc%0d ready: got %b expected %b", name, c, data_in_ready, ~got);
      end
      n_checks++;
      if (data_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s cyc%0d early_valid: got %b expected 0", name, c, data_out_valid);
      end
      tick();
      for (int i = 0; i < NL; i++) if (t[i] == c) got[i] = 1'b1;
    end
    for (int h = 0; h <= hold; h++) begin
      data_in_valid  = 3'($urandom);
      data_in        = 24'($urandom);
      data_out_ready = (h == hold);
      n_checks++;
      if (data_out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s emit%0d valid: got %b expected 1", name, h, data_out_valid);
      end
      n_checks++;
      if (data_out !== exp) begin
        n_fail++;
        $display("FAIL %s emit%0d data: got %h expected %h", name, h, data_out, exp);
      end
      n_checks++;
      if (data_in_ready !== 3'b000) begin
        n_fail++;
        $display("FAIL %s emit%0d ready: got %b expected 000", name, h, data_in_ready);
      end
      n_checks++;
      if (rot_out !== exp_r) begin
        n_fail++;
        $display("FAIL %s emit%0d rot: got %0d expected %0d", name, h, rot_out, exp_r);
      end
      tick();
    end
    m_txn++;
    data_in_valid  = '0;
    data_out_ready = 1'b0;
    n_checks++;
    if (data_out_valid !== 1'b0 || data_in_ready !== 3'b111) begin
      n_fail++;
      $display("FAIL %s post_accept: got valid %b ready %b expected valid 0 ready 111",
               name, data_out_valid, data_in_ready);
    end
    n_checks++;
    if (rot_out !== 2'(exp_rot())) begin
      n_fail++;
      $display("FAIL %s post_rot: got %0d expected %0d", name, rot_out, exp_rot());
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    data_in        = '0;
    data_in_valid  = '0;
    data_out_ready = 1'b0;
    repeat (2) tick();
    rst   = 1'b0;
    m_txn = 0;
    n_checks++;
    if (data_in_ready !== 3'b111) begin
      n_fail++;
      $display("FAIL reset ready: got %b expected 111", data_in_ready);
    end
    n_checks++;
    if (data_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset valid: got %b expected 0", data_out_valid);
    end
    n_checks++;
    if (data_out !== 24'h0) begin
      n_fail++;
      $display("FAIL reset data: got %h expected 000000", data_out);
    end
    n_checks++;
    if (rot_out !== 2'd0) begin
      n_fail++;
      $display("FAIL reset rot: got %0d expected 0", rot_out);
    end
  endtask

  task automatic test_simultaneous();
    run_txn(24'h332211, 0, 0, 0, 0, "simul");
  endtask

  task automatic test_staggered();
    run_txn(24'hCCBBAA, 3, 5, 0, 0, "stagger");
  endtask

  task automatic test_backpressure();
    run_txn(24'($urandom), 1, 0, 2, 10, "backpressure");
  endtask

  task automatic test_wrap();
    test_reset();
    for (int k = 0; k < 4; k++) run_txn(24'h332211, 0, 0, 0, 0, "wrap");
  endtask

  task automatic test_mid_reset();
    data_in        = 24'h00BBAA;
    data_in_valid  = 3'b011;
    data_out_ready = 1'b0;
    tick();
    data_in_valid = '0;
    n_checks++;
    if (data_in_ready !== 3'b100) begin
      n_fail++;
      $display("FAIL midrst partial_ready: got %b expected 100", data_in_ready);
    end
    test_reset();
    // Reset while a word is pending output must drop valid.
    data_in       = 24'h665544;
    data_in_valid = 3'b111;
    tick();
    data_in_valid = '0;
    n_checks++;
    if (data_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst pending_valid: got %b expected 1", data_out_valid);
    end
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    m_txn = 0;
    n_checks++;
    if (data_out_valid !== 1'b0 || data_in_ready !== 3'b111 || rot_out !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst emit_reset: got valid %b ready %b rot %0d expected 0 111 0",
               data_out_valid, data_in_ready, rot_out);
    end
    run_txn(24'h302010, 0, 1, 0, 1, "midrst_fresh");
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      run_txn(24'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_txn    = 0;
    test_reset();
    test_simultaneous();
    test_staggered();
    test_backpressure();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
